// File: rtl/bcd2bin_seq.sv
// rtl/bcd2bin_seq.sv - iterative BCD-to-binary converter, MSD first, valid/ready in and out.
// Optional nibble range check: define BCD2BIN_ERR_CHK_EN.
module bcd2bin_seq #(
  parameter int DIGITS = 4,
  parameter int BIN_W  = 14
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   bcd_in,
  input  logic                  bcd_vld,
  output logic                  bcd_rdy,
  output logic [BIN_W-1:0]      bin_out,
  output logic                  bin_vld,
  input  logic                  bin_rdy,
  output logic                  bcd_err
);

  localparam int SR_W = 4 * DIGITS;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CONV = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [2:0] LAST_CNT = 3'(DIGITS - 1);

  logic [1:0]       state_q,   state_d;
  logic [BIN_W-1:0] acc_q,     acc_d;
  logic [2:0]       cnt_q,     cnt_d;
  logic [SR_W-1:0]  sr_q,      sr_d;
  logic [BIN_W-1:0] bin_out_q, bin_out_d;
  logic             bin_vld_q, bin_vld_d;
  logic             bcd_rdy_q, bcd_rdy_d;

  logic [3:0]       nib;
  logic [BIN_W-1:0] acc_next;

  // acc*10 built from shifts; invalid nibbles simply wrap modulo 2^BIN_W
  assign nib      = sr_q[SR_W-1 -: 4];
  assign acc_next = (acc_q << 3) + (acc_q << 1) + BIN_W'(nib);

`ifdef BCD2BIN_ERR_CHK_EN
  logic err_q, err_d;
  logic err_next;
  logic bcd_err_q, bcd_err_d;

  assign err_next = err_q | (nib > 4'd9);
`endif

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    sr_d      = sr_q;
    bin_out_d = bin_out_q;
    bin_vld_d = bin_vld_q;
    bcd_rdy_d = bcd_rdy_q;
`ifdef BCD2BIN_ERR_CHK_EN
    err_d     = err_q;
    bcd_err_d = bcd_err_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (bcd_vld) begin
          sr_d      = bcd_in;
          acc_d     = '0;
          cnt_d     = '0;
          state_d   = ST_CONV;
          bcd_rdy_d = 1'b0;
`ifdef BCD2BIN_ERR_CHK_EN
          err_d     = 1'b0;
`endif
        end
      end
      ST_CONV: begin
        acc_d = acc_next;
        sr_d  = sr_q << 4;
        cnt_d = cnt_q + 3'd1;
`ifdef BCD2BIN_ERR_CHK_EN
        err_d = err_next;
`endif
        if (cnt_q == LAST_CNT) begin
          state_d   = ST_DONE;
          bin_vld_d = 1'b1;
`ifdef BCD2BIN_ERR_CHK_EN
          bin_out_d = err_next ? '0 : acc_next;
          bcd_err_d = err_next;
`else
          bin_out_d = acc_next;
`endif
        end
      end
      ST_DONE: begin
        if (bin_rdy) begin
          state_d   = ST_IDLE;
          bin_vld_d = 1'b0;
          bcd_rdy_d = 1'b1;
`ifdef BCD2BIN_ERR_CHK_EN
          bcd_err_d = 1'b0;
`endif
        end
      end
      default: begin
        state_d   = ST_IDLE;
        bin_vld_d = 1'b0;
        bcd_rdy_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      acc_q     <= '0;
      cnt_q     <= '0;
      sr_q      <= '0;
      bin_out_q <= '0;
      bin_vld_q <= 1'b0;
      bcd_rdy_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      sr_q      <= sr_d;
      bin_out_q <= bin_out_d;
      bin_vld_q <= bin_vld_d;
      bcd_rdy_q <= bcd_rdy_d;
    end
  end

`ifdef BCD2BIN_ERR_CHK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q     <= 1'b0;
      bcd_err_q <= 1'b0;
    end else begin
      err_q     <= err_d;
      bcd_err_q <= bcd_err_d;
    end
  end

  assign bcd_err = bcd_err_q;
`else
  assign bcd_err = 1'b0;
`endif

  assign bcd_rdy = bcd_rdy_q;
  assign bin_out = bin_out_q;
  assign bin_vld = bin_vld_q;

endmodule

// File: doc/bcd2bin_seq.md
Name: bcd2bin_seq

Overview:
- Iterative BCD-to-binary converter; the inverse of the bin2BCD pipeline.
- Accepts one packed DIGITS-digit BCD word through a valid/ready handshake.
- Folds in one digit per clock, most significant digit first, using acc = acc*10 + digit.
- Presents the binary result through a valid/ready output handshake, for the display/keypad paths that return decimal entry to binary.

Parameters:
- DIGITS, 4, number of BCD digits in the input word (1..5).
- BIN_W, 14, binary result width; must be >= ceil(log2(10^DIGITS)).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- bcd_in  input  4*DIGITS  packed BCD; digit k occupies bits [4k+3:4k]; digit DIGITS-1 is most significant.
- bcd_vld  input  1  bcd_in valid.
- bcd_rdy  output  1  block can accept a word.
- bin_out  output  BIN_W  binary result.
- bin_vld  output  1  bin_out valid.
- bin_rdy  input  1  downstream accepts bin_out.
- bcd_err  output  1  at least one nibble > 9 (ERR_CHK_EN only; otherwise tied 0). Qualified by bin_vld.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE; acc=0; digit counter=0; shift register=0.
  - bin_out=0, bin_vld=0, bcd_err=0, bcd_rdy=1. bcd_rdy is the registered decode of IDLE.
- States:
  - IDLE: bcd_rdy=1. On bcd_vld=1 at a rising edge: capture bcd_in into the shift register, acc=0, cnt=0, err=0, go to CONV.
  - CONV: bcd_rdy=0. Each cycle:
    - d = top nibble of the shift register.
    - acc = ((acc<<3)+(acc<<1)+d) truncated to BIN_W.
    - Shift the register left 4; cnt=cnt+1.
    - When cnt reaches DIGITS-1 on this update, go to DONE.
  - DONE: bin_vld=1; bin_out=acc; bcd_err held. On bin_rdy=1: bin_vld=0, go to IDLE.
- Latency and throughput:
  - Acceptance edge = edge 0. bin_vld rises after edge DIGITS (4 cycles at default).
  - bcd_rdy returns 1 the cycle after the bin_rdy handshake.
  - Minimum initiation interval DIGITS+2 cycles.
- Backpressure:
  - bin_out, bin_vld and bcd_err are held stable in DONE until bin_rdy=1, for any number of cycles.
  - bin_rdy has no effect outside DONE.
- bcd_vld outside IDLE is ignored; no skid buffer, the upstream must hold until bcd_rdy.
- DIGITS=1: CONV lasts one cycle.
- Width overflow cannot occur for valid BCD when the BIN_W rule is met. Invalid nibbles wrap modulo 2^BIN_W.
- Reset mid-CONV or mid-DONE aborts immediately: outputs return to reset values and no partial result is emitted.
- All outputs are registered; no combinational path from inputs to outputs.

Optional Feature:
- Macro: BCD2BIN_ERR_CHK_EN.
- Defined:
  - In CONV, any d > 9 sets the sticky err flag.
  - In DONE, bcd_err=err. If err=1, bin_out is forced to 0, not acc.
  - The conversion still takes DIGITS cycles.
- Undefined:
  - bcd_err is constant 0 and has no logic.
  - Invalid nibbles enter the arithmetic unchanged; the result is acc*10+d wrapped to BIN_W.

Test Plan:
- Reset then bcd_in=16'h0000 with bcd_vld=1 -> bcd_rdy drops next cycle; bin_vld=1 four cycles after acceptance; bin_out=0; bcd_err=0.
- bcd_in=16'h9999, bin_rdy=1 -> bin_out=14'd9999, valid for exactly one cycle; bcd_rdy=1 on the following cycle.
- bcd_in=16'h1234 with bin_rdy=0 for 10 cycles after bin_vld -> bin_out=1234 held stable, bcd_rdy=0 throughout, and a bcd_vld pulse during that time ignored. Release bin_rdy -> IDLE.
- Back-to-back words 16'h0042 then 16'h0100 with bcd_vld held high -> outputs 42 then 100; second word accepted only when bcd_rdy=1; interval 6 cycles.
- bcd_in=16'h12A4:
  - With BCD2BIN_ERR_CHK_EN -> bcd_err=1, bin_out=0.
  - Without -> bcd_err=0, bin_out=((1*10+2)*10+10)*10+4=1304.
- Assert rst for 1 cycle two cycles after accepting 16'h5678 -> bin_vld never rises for that word; bcd_rdy=1 after reset; next word 16'h0007 gives 7.
